// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame size, transmitter state encoding and parity helpers.
// Used by the device transmitter, the host receiver and the benches.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_GAP  = 2'd3
  } ps2_state_t;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Frame bit 0 is the start bit and goes on the wire first.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, odd_par(b), b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Circular byte FIFO: combinational head read, registered level; single-cycle push/pop.
// Caller must not push when full nor pop when empty; push and pop together keep level.
module ps2_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [W-1:0]  r_mem [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: push to start bit takes 2 cycles, 22*HALF per frame plus GAP*HALF idle.
// tx_ready falls when the byte FIFO is full and is held low during reset.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int HALF  = 8,
  parameter int GAP   = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic [7:0]             tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   ps2_clk,
  output logic                   ps2_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(GAP*HALF + 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP*HALF - 1);
  localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  ps2_state_t r_state, w_state_nxt;
  logic [CW-1:0]             r_div;
  logic [3:0]                r_bit_idx;
  logic [PS2_FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic                      r_ps2_clk, r_ps2_data, r_busy;
  logic                      w_push, w_pop, w_load, w_adv, w_full, w_empty;
  logic [7:0]                w_fifo_dout;
  logic [LW-1:0]             w_level, w_level_nxt;

  assign tx_ready    = clrn & ~w_full;
  assign w_push      = tx_valid & tx_ready;
  assign w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);

  ps2_tx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .i_push  (w_push),
    .i_din   (tx_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) begin
        w_state_nxt = ST_HIGH;
        w_pop       = 1'b1;
        w_load      = 1'b1;
      end
      ST_HIGH: if (r_div == '0) w_state_nxt = ST_LOW;
      ST_LOW: if (r_div == '0) begin
        if (r_bit_idx == LAST_BIT) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_HIGH;
          w_adv       = 1'b1;
        end
      end
      ST_GAP:  if (r_div == '0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_shift_nxt = r_shift;
    if (w_load)     w_shift_nxt = ps2_frame(w_fifo_dout);
    else if (w_adv) w_shift_nxt = {1'b1, r_shift[PS2_FRAME_BITS-1:1]};
  end

  // Outputs are registered from next-state values so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_div      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '1;
      r_ps2_clk  <= 1'b1;
      r_ps2_data <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      if (w_load)     r_bit_idx <= '0;
      else if (w_adv) r_bit_idx <= r_bit_idx + 4'd1;
      if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          ST_HIGH, ST_LOW: r_div <= HALF_LD;
          ST_GAP:          r_div <= GAP_LD;
          default:         r_div <= '0;
        endcase
      end else if (r_div != '0) begin
        r_div <= r_div - CW'(1);
      end
      r_ps2_clk  <= (w_state_nxt != ST_LOW);
      r_ps2_data <= (w_state_nxt == ST_HIGH || w_state_nxt == ST_LOW) ? w_shift_nxt[0] : 1'b1;
      r_busy     <= (w_state_nxt != ST_IDLE) || (w_level_nxt != '0);
    end
  end

  assign ps2_clk  = r_ps2_clk;
  assign ps2_data = r_ps2_data;
  assign busy     = r_busy;
  assign level    = w_level;

endmodule

// File: doc/ps2_device_tx.md
# ps2_device_tx

- Device-side PS/2 transmitter: serialises bytes into PS/2 device-to-host frames on `ps2_clk`/`ps2_data`.
- Pairs with the host-side keyboard receiver, in both the simulation keyboard model and loopback tests.
- Bytes (scan codes) enter via a valid/ready port into a small FIFO and are sent one frame at a time.
- Each frame is followed by a fixed idle gap.

## Interface
- `HALF`, default 8: system-clock cycles per PS/2 clock half-period; must be ≥ 4.
- `GAP`, default 4: idle half-periods inserted after each stop bit.
- `DEPTH`, default 8: FIFO entries; power of two.
- `clk`  in  1  system clock; the only clock.
- `clrn`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is offered.
- `tx_ready`  out  1  FIFO can accept; push occurs when `tx_valid & tx_ready`.
- `ps2_clk`  out  1  PS/2 clock; idle high.
- `ps2_data`  out  1  PS/2 data; idle high.
- `busy`  out  1  FSM not IDLE, or FIFO non-empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Frame is 11 bits, index 0..10:
  - bit 0: start, 0.
  - bits 1..8: D0..D7, LSB first.
  - bit 9: odd parity, `~^data`; XOR of bits 1..9 is 1.
  - bit 10: stop, 1.
- FSM states:
  - IDLE: lines high. If `level != 0`, pop the head byte, load the 11-bit shift register, set `bit_idx=0`, go to HIGH.
  - HIGH: `ps2_clk=1`, `ps2_data=frame[bit_idx]`, held for HALF cycles, then go to LOW.
  - LOW: `ps2_clk=0`, data unchanged, held for HALF cycles. If `bit_idx==10`, go to GAP; else `bit_idx++` and go to HIGH.
  - GAP: lines high for `GAP*HALF` cycles, then go to IDLE.
- Data changes only at the start of HIGH, never while `ps2_clk` is low. The host samples on the falling edge, so data is stable for HALF cycles before and after each fall.
- A single down-counter `div_cnt` times HIGH, LOW and GAP. It reloads on every state entry.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH.
  - `level` is 0..DEPTH.
  - `tx_ready = (level != DEPTH)`, forced 0 while `clrn==0`.
  - Push and pop in the same cycle leaves `level` unchanged.
  - Pop happens only in the IDLE→HIGH transition, at most once per frame.
  - No overflow is possible; a push while full cannot occur because `tx_ready` is low.
- Reset, including mid-frame: on the first edge with `clrn==0`:
  - `ps2_clk=1`, `ps2_data=1`.
  - FSM→IDLE, pointers and `level` = 0, `busy=0`.
  - Any partial frame is abandoned; it is never resumed.

## Timing
- Reset values: `ps2_clk=1`, `ps2_data=1`, `tx_ready=0` while in reset and 1 afterwards, `busy=0`, `level=0`.
- Latency into an empty, idle block:
  - Push at cycle t: `level=1` at t+1, and the FSM pops at t+1.
  - `ps2_data` falls to 0 at t+2.
  - First `ps2_clk` fall at t+2+HALF.
- Frame duration is `22*HALF` cycles, plus a `GAP*HALF` gap.
- Back-to-back frames: the next start bit appears one cycle (the IDLE pop) after the gap ends.
- All outputs are registered.

## Structure
- Shared package `ps2_pkg` holds:
  - `PS2_FRAME_BITS=11`.
  - State encoding IDLE/HIGH/LOW/GAP.
  - Parity function `odd_par(byte)`.
- This package is shared with the receiver and the bench.
- Sub-module `ps2_tx_fifo` (parameter DEPTH; push/pop/level/full/empty) is natural. The FSM, divider and shift register stay in the top level.

## Test plan
- **Single byte** (HALF=4, GAP=2): push 0x1C → at the 11 `ps2_clk` falls the sampled bits are 0,0,0,1,1,1,0,0,0,0,1. Frame lasts 88 cycles, then 8 idle cycles; `busy` drops in the cycle after GAP ends.
- **Parity corners**: send 0x00, 0xFF, 0x01 → parity bits 1, 1, 0. A bench receiver model reports no parity errors and decodes all three bytes.
- **Burst**: push 0xF0, 0x1C on consecutive cycles → two frames. The gap from the first stop-bit LOW end to the second start bit is exactly `GAP*HALF+1` cycles with lines high.
- **Fill**: hold `tx_valid=1` for 12 cycles from idle → pushes accepted on cycles 0..8 (9 bytes: one popped, 8 queued). `tx_ready=0` from cycle 9, `level=8`. All 9 bytes later emerge in order.
- **Reset mid-frame**: assert `clrn=0` for one cycle during bit 5 with 3 bytes queued. Next cycle both lines are 1, `level=0`, `busy=0`. A new push of 0x5A then produces a clean frame.
- **Idle**: `tx_valid=0` for 1000 cycles after reset → `ps2_clk=ps2_data=1` throughout, `busy=0`.
